// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: default parameters, counter
// widths and the receiver state encoding.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 8;
  localparam int DATA_BITS_DEF  = 8;

  localparam int TICK_CNT_W = $clog2(OVERSAMPLE_DEF);
  localparam int BIT_CNT_W  = $clog2(DATA_BITS_DEF);

  // Receiver states, kept as plain constants so older tooling can read them.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;
  localparam state_t ST_BREAK  = 3'd5;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line; both stages reset to the idle
// level (1) so reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make meta->q a real two-stage pipeline;
  // blocking ones here would collapse it into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver, oversampled by baud_tick, writing good bytes to a FIFO.
// Define UART_RX_PARITY_EN to expect an even-parity bit and add parity_err.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx_wire,
  input  logic                 data_in_full,
  output logic [DATA_BITS-1:0] data_in,
  output logic                 data_in_write,
  output logic                 framing_err,
`ifdef UART_RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 overrun_err
);

  localparam int TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  state_t               state;
  logic [TICK_W-1:0]    tick_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 parity_ok;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_wire),
    .q   (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic parity_bad;
  assign parity_ok = ~parity_bad;
`else
  assign parity_ok = 1'b1;
`endif

  // NOTE: the shift register is reset along with the control state so a
  // frame cut by reset leaves nothing behind for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      data_in       <= '0;
      data_in_write <= 1'b0;
      framing_err   <= 1'b0;
      overrun_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad    <= 1'b0;
      parity_err    <= 1'b0;
`endif
    end else begin
      // Strobes are one clk wide regardless of the tick rate.
      data_in_write <= 1'b0;
      framing_err   <= 1'b0;
      overrun_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err    <= 1'b0;
`endif
      if (baud_tick) begin
        case (state)
          ST_IDLE: begin
            if (!rx_s) begin
              tick_cnt <= '0;
              state    <= ST_START;
            end
          end
          ST_START: begin
            if (tick_cnt == HALF_LAST) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          ST_DATA: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
              shreg    <= DATA_BITS'({rx_s, shreg} >> 1);
              if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`ifdef UART_RX_PARITY_EN
          ST_PARITY: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt   <= '0;
              parity_bad <= rx_s ^ (^shreg);
              state      <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
`endif
          ST_STOP: begin
            if (tick_cnt == FULL_LAST) begin
              tick_cnt <= '0;
`ifdef UART_RX_PARITY_EN
              parity_err <= parity_bad;
`endif
              if (!rx_s) begin
                framing_err <= 1'b1;
                state       <= ST_BREAK;
              end else begin
                // Back to IDLE at mid-stop so a start bit half a bit later is seen.
                state <= ST_IDLE;
                if (parity_ok) begin
                  if (data_in_full) begin
                    overrun_err <= 1'b1;
                  end else begin
                    data_in       <= shreg;
                    data_in_write <= 1'b1;
                  end
                end
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          ST_BREAK: begin
            if (rx_s) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: directed frames push expected events,
// a negedge monitor pops and compares every strobe the receiver raises.
module tb_uart_rx_core;

  typedef enum logic [2:0] {EV_NONE, EV_WRITE, EV_FRAME, EV_OVERRUN, EV_PARITY} ev_e;
  typedef struct {
    ev_e        kind;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       baud_tick;
  logic       rx_wire;
  logic       data_in_full;
  logic [7:0] data_in;
  logic       data_in_write;
  logic       framing_err;
  logic       overrun_err;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int         n_checks = 0;
  int         n_errors = 0;
  exp_t       exp_q[$];
  logic [7:0] fifo_q[$];
  int         div;

  uart_rx_core #(.OVERSAMPLE(8), .DATA_BITS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .baud_tick     (baud_tick),
    .rx_wire       (rx_wire),
    .data_in_full  (data_in_full),
    .data_in       (data_in),
    .data_in_write (data_in_write),
    .framing_err   (framing_err),
`ifdef UART_RX_PARITY_EN
    .parity_err    (parity_err),
`endif
    .overrun_err   (overrun_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One baud tick every 4 clks, changed on the falling edge.
  initial begin
    baud_tick = 1'b0;
    div = 0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      baud_tick = (div == 0);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_ev(input ev_e kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_e kind, input logic [7:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      e.kind = EV_NONE;
      e.data = 8'h00;
    end else begin
      e = exp_q.pop_front();
    end
    check("event_kind", 32'(kind), 32'(e.kind));
    if (kind == EV_WRITE) begin
      check("data_in", 32'(data), 32'(e.data));
      fifo_q.push_back(data);
    end
  endtask

  // Monitor: samples strobes on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (data_in_write) observe(EV_WRITE, data_in);
        if (framing_err)   observe(EV_FRAME, 8'h00);
        if (overrun_err)   observe(EV_OVERRUN, 8'h00);
`ifdef UART_RX_PARITY_EN
        if (parity_err)    observe(EV_PARITY, 8'h00);
`endif
      end
    end
  end

  // Hold the line at level b for 'ticks' baud ticks.
  task automatic send_ticks(input logic b, input int ticks);
    int n;
    @(negedge clk);
    rx_wire = b;
    n = 0;
    while (n < ticks) begin
      @(posedge clk);
      if (baud_tick) n++;
    end
  endtask

  task automatic send_bit(input logic b);
    send_ticks(b, 8);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic par_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par_bit);
`else
    if (par_bit === 1'bx) send_bit(1'b1);
`endif
    send_bit(stop_bit);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b1, ^b);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_data_in"},       32'(data_in),       32'h00);
    check({tag, "_data_in_write"}, 32'(data_in_write), 32'h0);
    check({tag, "_framing_err"},   32'(framing_err),   32'h0);
    check({tag, "_overrun_err"},   32'(overrun_err),   32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    rx_wire      = 1'b1;
    data_in_full = 1'b0;
    repeat (4) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);

    // Back-to-back frames with no idle gap.
    expect_ev(EV_WRITE, 8'hAA);
    expect_ev(EV_WRITE, 8'h55);
    send_good(8'hAA);
    send_good(8'h55);
    send_bit(1'b1);
    check("fifo_count", 32'(fifo_q.size()), 32'd2);
    if (fifo_q.size() >= 2) begin
      check("fifo_rd0", 32'(fifo_q.pop_front()), 32'hAA);
      check("fifo_rd1", 32'(fifo_q.pop_front()), 32'h55);
    end

    // Glitch: 2 ticks low, then idle; nothing may be reported.
    send_ticks(1'b0, 2);
    send_ticks(1'b1, 22);
    check("glitch_data_in", 32'(data_in), 32'h55);

    // Framing error, then recovery after one idle bit.
    expect_ev(EV_FRAME, 8'h00);
    send_frame(8'h3C, 1'b0, ^8'h3C);
    send_bit(1'b1);
    expect_ev(EV_WRITE, 8'h81);
    send_good(8'h81);
    send_bit(1'b1);

    // Overrun: FIFO full during the stop sample drops the byte.
    data_in_full = 1'b1;
    expect_ev(EV_OVERRUN, 8'h00);
    send_good(8'h5A);
    send_bit(1'b1);
    data_in_full = 1'b0;
    check("overrun_data_hold", 32'(data_in), 32'h81);
    expect_ev(EV_WRITE, 8'h5A);
    send_good(8'h5A);
    send_bit(1'b1);

    // Reset after 3 data bits of 0xFF.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_quiet("midreset");
    send_bit(1'b1);
    send_bit(1'b1);
    expect_ev(EV_WRITE, 8'hC3);
    send_good(8'hC3);
    send_bit(1'b1);

`ifdef UART_RX_PARITY_EN
    expect_ev(EV_WRITE, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    send_bit(1'b1);
    expect_ev(EV_PARITY, 8'h00);
    send_frame(8'h07, 1'b1, 1'b0);
    send_bit(1'b1);
    check("parity_data_hold", 32'(data_in), 32'h07);
`endif

    send_bit(1'b1);
    check("pending_expect", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- 8N1 UART receiver. Oversamples `rx_wire` at 8x the baud rate using an external `baud_tick` enable from the baud generator.
- Each byte is reassembled LSB-first.
- Each good byte is pushed into the downstream receive FIFO with a one-cycle write strobe. The FIFO's full flag is honoured.

Parameters:
- OVERSAMPLE, 8, baud_tick pulses per bit period; power of two, at least 4.
- DATA_BITS, 8, data bits per frame; also the width of `data_in`.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- baud_tick  in  1  one-clk-wide enable, OVERSAMPLE per bit period.
- rx_wire  in  1  asynchronous serial line; idles high.
- data_in_full  in  1  FIFO full flag (write side).
- data_in  out  DATA_BITS  received byte presented to the FIFO.
- data_in_write  out  1  FIFO write request; one clk pulse per accepted byte.
- framing_err  out  1  one-clk pulse: stop bit sampled low.
- overrun_err  out  1  one-clk pulse: byte dropped because the FIFO was full.

Behaviour:
- Input synchronisation:
  - `rx_wire` passes through a 2-flop synchroniser; both flops reset to 1.
  - All sampling uses the synchronised value.
- Reset values: `data_in`=0, `data_in_write`=0, `framing_err`=0, `overrun_err`=0, state=IDLE, counters=0, shift register=0.
- Clock gating of the state machine:
  - State and counters advance only on clk cycles with `baud_tick`=1.
  - Output strobes are generated per clk cycle.
- States:
  - IDLE: on a tick with line=0, clear tick_cnt and go to START.
  - START: on the tick where tick_cnt reaches OVERSAMPLE/2-1 (mid-bit), sample the line.
    - Line=0: go to DATA with bit_cnt=0 and tick_cnt=0.
    - Line=1 (glitch): return to IDLE; no output.
  - DATA: every OVERSAMPLE ticks (mid-bit), shift the sample in at the MSB side; after DATA_BITS shifts the first-received bit sits at bit 0 (LSB-first).
    - After DATA_BITS samples, go to STOP.
  - STOP: sample at mid-bit.
    - Line=1 and `data_in_full`=0: latch the shift register into `data_in`; pulse `data_in_write` for exactly one clk on the following cycle. `data_in` holds its value until the next accepted byte.
    - Line=1 and `data_in_full`=1: no write; pulse `overrun_err` for one clk. The byte is lost.
    - Line=0: no write; pulse `framing_err`; go to BREAK.
    - Otherwise (line=1 cases): go to IDLE immediately after the stop mid-sample, so a start edge arriving half a bit later is caught.
  - BREAK: wait until a tick with line=1, then go to IDLE.
- Fullness check: `data_in_full` is evaluated in the same clk as the stop mid-sample.
- Frame timing: the start bit of the next frame may follow the stop bit immediately (back-to-back frames); no inter-frame idle is required.
- Write latency: `data_in_write` rises 1 clk after the stop-bit mid-sample tick.
- Missing ticks: `baud_tick` stuck low freezes the state machine; no timeout.
- Reset mid-frame: the partial byte is discarded; the next frame is received cleanly.

Optional Feature:
- Macro: `UART_RX_PARITY_EN`.
- When defined:
  - One even-parity bit is expected between the last data bit and the stop bit, in state PARITY, sampled at mid-bit.
  - Mismatch: no write; add output `parity_err` (one-clk pulse); still check the stop bit.
- When undefined: pure 8N1; no PARITY state and no `parity_err` port.

Decomposition:
- Package `uart_pkg`:
  - state enum IDLE/START/DATA/PARITY/STOP/BREAK;
  - default OVERSAMPLE and DATA_BITS constants;
  - tick-counter and bit-counter width localparams derived via $clog2.
- One sub-module: `uart_rx_sync`, the 2-flop synchroniser with reset-to-1.

Test Plan:
- Back-to-back frames: 0xAA then 0x55 sent LSB-first, 8 ticks/bit, no gap between frames -> exactly two `data_in_write` pulses, `data_in`=0xAA then 0x55; the FIFO reads back 0xAA, 0x55 in order.
- Glitch: line low for 2 ticks, then high -> returns to IDLE; no strobe of any kind.
- Framing error, then recovery:
  - Frame 0x3C with stop bit=0 -> `framing_err` pulses once; no write.
  - Line high for 1 bit, then frame 0x81 -> one write of 0x81.
- Overrun: `data_in_full`=1 during frame 0x5A -> no write, one `overrun_err` pulse; next frame 0x5A with full=0 -> written.
- Reset mid-frame: `rst` for 1 clk after 3 data bits of 0xFF -> all outputs 0; following frame 0xC3 -> single write of 0xC3.
- Parity (`UART_RX_PARITY_EN` defined): 0x07 with parity=1 -> written; 0x07 with parity=0 -> `parity_err` pulse, no write.
